// File: rtl/i2c_slv_regbank.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slv_regbank
// Brief    : I2C slave with glitch-filtered inputs, START/STOP decode, 7-bit
//            address match and a pointer-addressed register bank with
//            auto-increment, shared with a local host port.
// Revision : 1.0 - first release
// ============================================================================
module i2c_slv_regbank #(
    parameter int         DATA_SZ  = 8,
    parameter logic [6:0] ADDR_SLV = 7'h50,
    parameter int         REG_NUM  = 16,
    parameter int         FLT_LEN  = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       I_SCL,
    input  logic                       I_SDA,
    output logic                       O_SDA_OE,
    input  logic [$clog2(REG_NUM)-1:0] I_HST_ADDR,
    input  logic                       I_HST_WE,
    input  logic [DATA_SZ-1:0]         I_HST_DATA,
    output logic [DATA_SZ-1:0]         O_HST_DATA,
    output logic                       O_WR_STB,
    output logic [$clog2(REG_NUM)-1:0] O_WR_ADDR,
    output logic                       O_RD_STB,
    output logic                       O_BUSY,
    output logic                       O_ERR
);

    localparam int                   c_ptr_w    = $clog2(REG_NUM);
    localparam logic [3:0]           c_flt_last = 4'(FLT_LEN - 1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one  = 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR       = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD       = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: index 0 is SCL, index 1 is SDA
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_filt;
    logic [1:0] r_filt_d;
    logic [3:0] r_fcnt [2];

    assign w_raw = {I_SDA, I_SCL};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            // The filtered level only moves after FLT_LEN consecutive disagreeing samples
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == c_flt_last) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 4'd1;
                end
            end
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_sda_rise = r_filt[1] & ~r_filt_d[1];
    assign w_sda_fall = ~r_filt[1] & r_filt_d[1];
    assign w_start    = w_sda_fall & r_filt[0];
    assign w_stop     = w_sda_rise & r_filt[0];

    // ------------------------------------------------------------------
    // Protocol state and register bank
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [7:0]           r_shift;
    logic [2:0]           r_bitcnt;
    logic                 r_phase;
    logic                 r_rw;
    logic                 r_mack;
    logic [c_ptr_w-1:0]   r_ptr;
    logic                 r_sda_oe;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_wr_stb;
    logic [c_ptr_w-1:0]   r_wr_addr;
    logic                 r_rd_stb;
    logic [DATA_SZ-1:0]   r_bank [REG_NUM];
    logic [DATA_SZ-1:0]   r_hst_rdata;

    logic [7:0]           w_byte;
    logic [c_ptr_w-1:0]   w_ptr_inc;
    logic                 w_rx_state;
    logic                 w_in_byte;
    logic                 w_i2c_we;

    assign w_byte     = {r_shift[6:0], r_filt[1]};
    assign w_ptr_inc  = r_ptr + c_ptr_one;
    assign w_rx_state = (r_state == S_ADDR) || (r_state == S_PTR) ||
                        (r_state == S_WR)   || (r_state == S_RD);
    assign w_in_byte  = w_rx_state && (r_bitcnt != 3'd0) && r_busy;
    assign w_i2c_we   = (r_state == S_WR) && w_scl_rise && (r_bitcnt == 3'd7) &&
                        !w_start && !w_stop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_phase   <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_rd_stb  <= 1'b0;
        end else begin
            r_wr_stb <= 1'b0;
            r_rd_stb <= 1'b0;
            if (w_stop) begin
                if (w_in_byte) begin
                    r_err <= 1'b1;
                end
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
            end else if (w_start) begin
                if (w_in_byte) begin
                    r_err <= 1'b1;
                end
                r_state  <= S_ADDR;
                r_sda_oe <= 1'b0;
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_phase <= 1'b0;
                                if (r_state == S_ADDR) begin
                                    if (w_byte[7:1] == ADDR_SLV) begin
                                        r_state <= S_ADDR_ACK;
                                        r_rw    <= w_byte[0];
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_state <= S_IGNORE;
                                        r_busy  <= 1'b0;
                                    end
                                end else if (r_state == S_PTR) begin
                                    r_ptr   <= w_byte[c_ptr_w-1:0];
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    r_wr_stb  <= 1'b1;
                                    r_wr_addr <= r_ptr;
                                    r_ptr     <= w_ptr_inc;
                                    r_state   <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK pulse, the second ends it
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= 1'b1;
                                r_phase  <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if ((r_state == S_ADDR_ACK) && r_rw) begin
                                    r_shift  <= r_bank[r_ptr];
                                    r_sda_oe <= ~r_bank[r_ptr][7];
                                    r_rd_stb <= 1'b1;
                                    r_state  <= S_RD;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WR;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= S_RD_ACK;
                                r_phase <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_mack  <= ~r_filt[1];
                            r_phase <= 1'b1;
                        end else if (w_scl_fall && !r_phase) begin
                            r_sda_oe <= 1'b0;
                        end else if (w_scl_fall && r_phase) begin
                            r_phase <= 1'b0;
                            if (r_mack) begin
                                r_ptr    <= w_ptr_inc;
                                r_shift  <= r_bank[w_ptr_inc];
                                r_sda_oe <= ~r_bank[w_ptr_inc][7];
                                r_rd_stb <= 1'b1;
                                r_state  <= S_RD;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_IGNORE;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // I2C write is ordered after the host write so it wins on a shared index
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_bank[i] <= '0;
            end
            r_hst_rdata <= '0;
        end else begin
            if (I_HST_WE) begin
                r_bank[I_HST_ADDR] <= I_HST_DATA;
            end
            if (w_i2c_we) begin
                r_bank[r_ptr] <= w_byte;
            end
            r_hst_rdata <= r_bank[I_HST_ADDR];
        end
    end

    assign O_SDA_OE   = r_sda_oe;
    assign O_HST_DATA = r_hst_rdata;
    assign O_WR_STB   = r_wr_stb;
    assign O_WR_ADDR  = r_wr_addr;
    assign O_RD_STB   = r_rd_stb;
    assign O_BUSY     = r_busy;
    assign O_ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slv_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slv_regbank
// Brief    : Bit-banged I2C master plus transaction-level register model.
// Revision : 1.0 - first release
// ============================================================================
module tb_i2c_slv_regbank;

    localparam int         Q   = 8;
    localparam int         RN  = 16;
    localparam logic [6:0] SLV = 7'h50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic [3:0] hst_addr = '0;
    logic       hst_we = 1'b0;
    logic [7:0] hst_data = '0;
    logic [7:0] hst_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic       rd_stb;
    logic       busy;
    logic       err;
    wire        sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slv_regbank #(.DATA_SZ(8), .ADDR_SLV(SLV), .REG_NUM(RN), .FLT_LEN(3)) u_dut (
        .CLK(clk), .RST(rst), .I_SCL(m_scl), .I_SDA(sda_line), .O_SDA_OE(sda_oe),
        .I_HST_ADDR(hst_addr), .I_HST_WE(hst_we), .I_HST_DATA(hst_data),
        .O_HST_DATA(hst_rdata), .O_WR_STB(wr_stb), .O_WR_ADDR(wr_addr),
        .O_RD_STB(rd_stb), .O_BUSY(busy), .O_ERR(err)
    );

    // Reference model state
    logic [7:0] ref_bank [RN];
    int         ref_ptr = 0;
    logic [7:0] tx_buf [8];

    int n_chk  = 0;
    int n_fail = 0;

    // Strobe / activity monitor
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         oe_cyc = 0;
    int         busy_cyc = 0;
    logic [3:0] wr_log [1024];

    always @(negedge clk) begin
        if (wr_stb) begin
            if (wr_cnt < 1024) wr_log[wr_cnt] = wr_addr;
            wr_cnt++;
        end
        if (rd_stb) rd_cnt++;
        if (sda_oe) oe_cyc++;
        if (busy) busy_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- bit-level master ----------------
    task automatic m_start();
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(2*Q);
        m_sda = 1'b0; cyc(2*Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(2*Q);
        m_sda = 1'b1; cyc(2*Q);
    endtask

    task automatic m_bits(input logic [7:0] b, input int nb, input bit glitch);
        for (int i = 7; i > 7 - nb; i--) begin
            m_sda = b[i]; cyc(Q);
            m_scl = 1'b1;
            if (glitch) begin
                cyc(Q); m_scl = 1'b0; cyc(1); m_scl = 1'b1; cyc(Q-1);
            end else begin
                cyc(2*Q);
            end
            m_scl = 1'b0;
            if (glitch) begin
                cyc(3); m_scl = 1'b1; cyc(1); m_scl = 1'b0; cyc(Q-4);
            end else begin
                cyc(Q);
            end
        end
    endtask

    task automatic m_wbyte(input logic [7:0] b, input bit glitch, output bit ack);
        m_bits(b, 8, glitch);
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        ack = ~sda_line;
        cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic m_rbyte(input bit ack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            cyc(Q); m_scl = 1'b1;
            cyc(Q); b[i] = sda_line;
            cyc(Q); m_scl = 1'b0;
            cyc(Q);
        end
        m_sda = ack ? 1'b0 : 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(2*Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    // ---------------- host port ----------------
    task automatic host_write(input int idx, input logic [7:0] d);
        hst_addr = 4'(idx); hst_data = d; hst_we = 1'b1;
        cyc(1);
        hst_we = 1'b0;
        ref_bank[idx] = d;
    endtask

    task automatic host_read(input int idx, output logic [7:0] d);
        hst_addr = 4'(idx);
        cyc(2);
        d = hst_rdata;
    endtask

    task automatic compare_bank();
        logic [7:0] d;
        for (int i = 0; i < RN; i++) begin
            host_read(i, d);
            check($sformatf("bank[%0d]", i), d, ref_bank[i]);
        end
    endtask

    // ---------------- transactions ----------------
    task automatic i2c_write(input logic [7:0] ptr, input int n, input bit glitch, input bit do_stop);
        bit ack;
        int w0;
        int exp_a [8];
        w0 = wr_cnt;
        m_start();
        m_wbyte({SLV, 1'b0}, 1'b0, ack);
        check("wr_addr_ack", ack, 1);
        check("busy_addressed", busy, 1);
        m_wbyte(ptr, glitch, ack);
        check("wr_ptr_ack", ack, 1);
        ref_ptr = ptr % RN;
        for (int i = 0; i < n; i++) begin
            m_wbyte(tx_buf[i], glitch, ack);
            check("wr_data_ack", ack, 1);
            exp_a[i] = ref_ptr;
            ref_bank[ref_ptr] = tx_buf[i];
            ref_ptr = (ref_ptr + 1) % RN;
        end
        if (do_stop) begin
            m_stop();
            check("busy_after_stop", busy, 0);
        end
        check("wr_stb_count", wr_cnt - w0, n);
        for (int i = 0; i < n; i++) begin
            check("wr_stb_addr", wr_log[w0 + i], exp_a[i]);
        end
    endtask

    task automatic i2c_read(input int n, input bit set_ptr, input logic [7:0] ptr);
        bit ack;
        int r0;
        logic [7:0] b;
        if (set_ptr) i2c_write(ptr, 0, 1'b0, 1'b0);
        r0 = rd_cnt;
        m_start();
        m_wbyte({SLV, 1'b1}, 1'b0, ack);
        check("rd_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            m_rbyte(i < n - 1, b);
            check("rd_data", b, ref_bank[ref_ptr]);
            if (i < n - 1) ref_ptr = (ref_ptr + 1) % RN;
        end
        m_stop();
        check("rd_stb_count", rd_cnt - r0, n);
        check("busy_after_rd", busy, 0);
    endtask

    task automatic wrong_addr();
        bit ack;
        int o0, b0;
        o0 = oe_cyc; b0 = busy_cyc;
        m_start();
        m_wbyte({7'h51, 1'b0}, 1'b0, ack);
        check("nack_addr", ack, 0);
        m_wbyte(8'($urandom), 1'b0, ack);
        check("nack_data", ack, 0);
        m_stop();
        check("oe_cycles_foreign", oe_cyc - o0, 0);
        check("busy_cycles_foreign", busy_cyc - b0, 0);
    endtask

    task automatic collide();
        bit ack;
        bit seen;
        logic [7:0] d;
        seen = 1'b0;
        m_start();
        m_wbyte({SLV, 1'b0}, 1'b0, ack);
        m_wbyte(8'h05, 1'b0, ack);
        check("col_ptr_ack", ack, 1);
        fork
            m_wbyte(8'h77, 1'b0, ack);
            begin
                hst_addr = 4'd5; hst_data = 8'hEE; hst_we = 1'b1;
                for (int k = 0; k < 4000; k++) begin
                    cyc(1);
                    if (wr_stb) begin
                        seen = 1'b1;
                        break;
                    end
                end
                hst_we = 1'b0;
            end
        join
        check("col_wr_stb_seen", seen, 1);
        check("col_data_ack", ack, 1);
        m_stop();
        ref_bank[5] = 8'h77;
        ref_ptr = 6;
        host_read(5, d);
        check("col_bank5", d, 8'h77);
    endtask

    // ---------------- main ----------------
    initial begin
        logic [7:0] d;
        bit ack;
        for (int i = 0; i < RN; i++) ref_bank[i] = 8'h00;

        rst = 1'b1;
        cyc(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_rd_stb", rd_stb, 0);
        check("rst_hst_data", hst_rdata, 0);
        rst = 1'b0;
        cyc(10);

        // Pointer write then two data bytes
        tx_buf[0] = 8'hA5; tx_buf[1] = 8'h5A;
        i2c_write(8'h03, 2, 1'b0, 1'b1);
        host_read(3, d); check("bank3", d, 8'hA5);
        host_read(4, d); check("bank4", d, 8'h5A);

        // Read with wrap from the last index
        host_write(15, 8'h11); host_write(0, 8'h22); host_write(1, 8'h33);
        i2c_read(3, 1'b1, 8'h0F);

        wrong_addr();

        // SCL glitches inside the bytes
        tx_buf[0] = 8'hC3; tx_buf[1] = 8'h3C;
        i2c_write(8'h08, 2, 1'b1, 1'b1);

        collide();

        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    for (int i = 0; i < 8; i++) tx_buf[i] = 8'($urandom);
                    i2c_write(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b0, 1'b1);
                end
                1: i2c_read(int'($urandom_range(1, 4)), 1'b1, 8'($urandom_range(0, 255)));
                2: i2c_read(int'($urandom_range(1, 3)), 1'b0, 8'h00);
                default: begin
                    host_write(int'($urandom_range(0, RN - 1)), 8'($urandom));
                    wrong_addr();
                end
            endcase
        end
        compare_bank();

        // STOP after four bits of a data byte
        m_start();
        m_wbyte({SLV, 1'b0}, 1'b0, ack);
        m_wbyte(8'h02, 1'b0, ack);
        ref_ptr = 2;
        m_bits(8'hFF, 4, 1'b0);
        m_stop();
        check("err_sticky", err, 1);
        check("err_sda_released", sda_oe, 0);
        check("err_busy_idle", busy, 0);
        host_read(2, d);
        check("err_bank2_kept", d, ref_bank[2]);

        // Reset in the middle of a read byte whose MSB is zero
        host_write(9, 8'h00);
        host_write(10, 8'h6B);
        i2c_write(8'h09, 0, 1'b0, 1'b0);
        m_start();
        m_wbyte({SLV, 1'b1}, 1'b0, ack);
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        check("rd_msb_driven", sda_oe, 1);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_wr_stb", wr_stb, 0);
        check("mid_rst_rd_stb", rd_stb, 0);
        check("mid_rst_hst_data", hst_rdata, 0);
        rst = 1'b0;
        for (int i = 0; i < RN; i++) ref_bank[i] = 8'h00;
        ref_ptr = 0;
        cyc(4*Q);

        // Bus usable again after a fresh START
        tx_buf[0] = 8'h9D;
        i2c_write(8'h0A, 1, 1'b0, 1'b1);
        i2c_read(1, 1'b0, 8'h00);
        compare_bank();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/i2c_slv_regbank.md
# i2c_slv_regbank

Parametrised I2C slave with a built-in register bank, the next generation of the existing I2C slave top. It filters and edge-detects the raw SCL/SDA lines, decodes START/repeated START/STOP, matches a configurable 7-bit address, and serves standard pointer-based register reads and writes with auto-increment. A host-side port gives local logic simultaneous access to the same bank.

## Interface
- DATA_SZ, 8, data and register width; the I2C byte is always 8 bits, so only 8 is legal
- ADDR_SLV, 7'h50, own 7-bit slave address
- REG_NUM, 16, register count; power of two, 2..256
- FLT_LEN, 3, glitch-filter length in CLK cycles, 1..15
- CLK  in  1  system clock, the only clock
- RST  in  1  synchronous reset, active-high
- I_SCL  in  1  raw I2C SCL
- I_SDA  in  1  raw I2C SDA, read back from the pad
- O_SDA_OE  out  1  1 = pull SDA low, 0 = release (pad: IO_SDA = O_SDA_OE ? 0 : z)
- I_HST_ADDR  in  log2(REG_NUM)  host register index
- I_HST_WE  in  1  host write strobe
- I_HST_DATA  in  DATA_SZ  host write data
- O_HST_DATA  out  DATA_SZ  bank[I_HST_ADDR], registered, 1-cycle latency
- O_WR_STB  out  1  1-cycle pulse when an I2C write lands in the bank
- O_WR_ADDR  out  log2(REG_NUM)  index of that write
- O_RD_STB  out  1  1-cycle pulse when a byte is loaded for I2C read
- O_BUSY  out  1  high from START to STOP while addressed
- O_ERR  out  1  sticky: address NACKed, or master NACK on a non-final byte is not an error; set only on a bus protocol error (see below); cleared by RST

## Operation
- Input path: 2-FF synchroniser per line, then a filter that updates its output only after FLT_LEN consecutive equal samples. Rising/falling edge flags come from the filtered signals.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while SCL is high. Both are legal in any state; a START in any non-IDLE state acts as a repeated START.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- IDLE -> ADDR on START. ADDR shifts 8 bits MSB-first on SCL rising edges. If addr[7:1] == ADDR_SLV, go to ADDR_ACK; otherwise go to IGNORE, with no ACK.
- In ADDR_ACK, SDA is driven low for one SCL clock. Then R/W=0 -> PTR, or R/W=1 -> RD, where bank[ptr] is loaded into the shifter and O_RD_STB pulses.
- PTR: receive byte, ptr <= byte mod REG_NUM, ACK -> WR.
- WR: receive byte, write bank[ptr], pulse O_WR_STB with O_WR_ADDR=ptr, ACK, ptr <= ptr+1 mod REG_NUM -> WR.
- RD: drive 8 bits MSB-first, then release SDA for the master ACK bit. On ACK: ptr+1 wraps mod REG_NUM, load the next byte, pulse O_RD_STB -> RD. On NACK -> IGNORE.
- IGNORE: SDA released; wait for START or STOP.
- STOP in any state -> IDLE, SDA released. The pointer is retained across transactions.
- Protocol error (sets O_ERR): START or STOP seen in the middle of a byte (bit count 1..7) while addressed.
- Simultaneous host write and I2C write to the same index in the same cycle: the I2C write wins. O_HST_DATA shows the winning value next cycle.
- A host write to the index currently loaded for read does not alter the byte already in the shifter.

## Timing
- Reset values: O_SDA_OE=0, O_HST_DATA=0, O_WR_STB=0, O_WR_ADDR=0, O_RD_STB=0, O_BUSY=0, O_ERR=0, all bank registers=0, ptr=0, FSM=IDLE.
- Filter latency: raw line change to edge flag is 2+FLT_LEN+1 CLK cycles.
- Data is sampled on the CLK cycle carrying the filtered-SCL rising flag.
- O_SDA_OE changes only on the cycle after a filtered-SCL falling flag, or on STOP/START/RST.
- O_WR_STB pulses on the cycle after the 8th rising SCL of a data byte. The bank is updated on that same edge.
- Minimum SCL high or low time is FLT_LEN+4 CLK cycles; no clock stretching.
- RST mid-transfer releases SDA on the next CLK edge. The bus is then ignored until a fresh START.

## Test plan
- Write 0x50<<1|0, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; bank[3]=0xA5, bank[4]=0x5A; two O_WR_STB pulses with O_WR_ADDR 3 then 4; O_BUSY low after STOP.
- Write ptr 0x0F, repeated START, read 3 bytes with ACK, ACK, NACK (preload bank[15]=0x11, bank[0]=0x22, bank[1]=0x33) -> master reads 0x11, 0x22, 0x33 (wrap); three O_RD_STB pulses.
- Address 0x51 write -> no ACK, SDA never driven, bank unchanged, O_BUSY stays 0.
- 1-cycle glitches on SCL during a byte with FLT_LEN=3 -> no extra bits shifted; received data is correct.
- Host write to index 5 in the same cycle as an I2C write of 0x77 to index 5 -> bank[5]=0x77.
- STOP after 4 bits of a data byte -> O_ERR=1, FSM IDLE, SDA released. RST asserted mid-read -> all outputs return to reset values on the next cycle.
